// File: rtl/rcv_sample_packer.sv
// Packs LSB/MSB byte pairs from the UART receiver into 16-bit FIR samples.
// Inter-byte timeout resynchronises after a lost byte; sticky flags report timeouts and overruns.
module rcv_sample_packer #(
   parameter int unsigned TIMEOUT_CYC = 50000,
   parameter int unsigned TMR_W       = 16,
   parameter int unsigned CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             RxD_data_ready,
   input  logic [7:0]       RxD_data,
   input  logic             FIR_busy,
   input  logic             err_clr,
   output logic [15:0]      FIR_in,
   output logic             FIR_start,
   output logic [CNT_W-1:0] sample_cnt,
   output logic             timeout_err,
   output logic             overrun
);

   typedef enum logic [1:0] {StWaitLsb, StWaitMsb, StIssue, StHold} state_e;

   state_e             state_q, state_d;
   logic [7:0]         lsb_q, lsb_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic [15:0]        fir_in_q, fir_in_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               tout_q, tout_d;
   logic               ovr_q, ovr_d;
   logic               timer_expired;

   assign timer_expired = (timer_q == TMR_W'(TIMEOUT_CYC - 1));

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StWaitLsb;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StWaitLsb: begin
            if (RxD_data_ready) state_d = StWaitMsb;
         end
         StWaitMsb: begin
            if (RxD_data_ready) begin
               state_d = FIR_busy ? StHold : StIssue;
            end else if (timer_expired) begin
               state_d = StWaitLsb;
            end
         end
         StIssue: begin
            state_d = RxD_data_ready ? StWaitMsb : StWaitLsb;
         end
         StHold: begin
            if (!FIR_busy) state_d = StIssue;
         end
         default: state_d = StWaitLsb;
      endcase
   end

   // Datapath and flag registers
   always_ff @(posedge clk) begin
      if (rst) begin
         lsb_q    <= '0;
         timer_q  <= '0;
         fir_in_q <= '0;
         cnt_q    <= '0;
         tout_q   <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         lsb_q    <= lsb_d;
         timer_q  <= timer_d;
         fir_in_q <= fir_in_d;
         cnt_q    <= cnt_d;
         tout_q   <= tout_d;
         ovr_q    <= ovr_d;
      end
   end

   // Datapath and flag next values; a set in the same cycle as err_clr wins
   always_comb begin
      lsb_d    = lsb_q;
      timer_d  = timer_q;
      fir_in_d = fir_in_q;
      cnt_d    = cnt_q;
      tout_d   = err_clr ? 1'b0 : tout_q;
      ovr_d    = err_clr ? 1'b0 : ovr_q;
      unique case (state_q)
         StWaitLsb: begin
            if (RxD_data_ready) begin
               lsb_d   = RxD_data;
               timer_d = '0;
            end
         end
         StWaitMsb: begin
            if (RxD_data_ready) begin
               fir_in_d = {RxD_data, lsb_q};
            end else if (timer_expired) begin
               tout_d = 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         StIssue: begin
            cnt_d = cnt_q + 1'b1;
            if (RxD_data_ready) begin
               lsb_d   = RxD_data;
               timer_d = '0;
            end
         end
         StHold: begin
            if (RxD_data_ready) ovr_d = 1'b1;
         end
         default: ;
      endcase
   end

   // Outputs
   always_comb begin
      FIR_start   = (state_q == StIssue);
      FIR_in      = fir_in_q;
      sample_cnt  = cnt_q;
      timeout_err = tout_q;
      overrun     = ovr_q;
   end

endmodule

// File: tb/tb_rcv_sample_packer.sv
// Directed self-checking bench for rcv_sample_packer with a 200-cycle inter-byte timeout.
module tb_rcv_sample_packer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        RxD_data_ready = 1'b0;
   logic [7:0]  RxD_data = 8'h00;
   logic        FIR_busy = 1'b0;
   logic        err_clr = 1'b0;
   logic [15:0] FIR_in;
   logic        FIR_start;
   logic [7:0]  sample_cnt;
   logic        timeout_err;
   logic        overrun;

   int checks = 0;
   int errors = 0;
   int pulse_cnt = 0;
   int dbl_cnt = 0;
   logic prev_start = 1'b0;
   int snap;

   rcv_sample_packer #(
      .TIMEOUT_CYC(200),
      .TMR_W      (16),
      .CNT_W      (8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .RxD_data_ready(RxD_data_ready),
      .RxD_data      (RxD_data),
      .FIR_busy      (FIR_busy),
      .err_clr       (err_clr),
      .FIR_in        (FIR_in),
      .FIR_start     (FIR_start),
      .sample_cnt    (sample_cnt),
      .timeout_err   (timeout_err),
      .overrun       (overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (FIR_start) pulse_cnt <= pulse_cnt + 1;
      if (FIR_start && prev_start) dbl_cnt <= dbl_cnt + 1;
      prev_start <= FIR_start;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      RxD_data_ready = 1'b1;
      RxD_data       = b;
      tick(1);
      RxD_data_ready = 1'b0;
      RxD_data       = 8'h00;
   endtask

   initial begin
      // Reset state
      tick(2);
      rst = 1'b0;
      check("rst_fir_in", 32'(FIR_in), 32'h0);
      check("rst_start", 32'(FIR_start), 32'h0);
      check("rst_cnt", 32'(sample_cnt), 32'h0);
      check("rst_tout", 32'(timeout_err), 32'h0);
      check("rst_ovr", 32'(overrun), 32'h0);

      // 1: basic pair, MSB 100 cycles after LSB
      send(8'h34);
      tick(100);
      snap = pulse_cnt;
      send(8'h12);
      check("t1_fir_in", 32'(FIR_in), 32'h1234);
      check("t1_start_hi", 32'(FIR_start), 32'h1);
      tick(1);
      check("t1_start_lo", 32'(FIR_start), 32'h0);
      check("t1_cnt", 32'(sample_cnt), 32'h1);
      check("t1_pulses", 32'(pulse_cnt - snap), 32'h1);

      // 2: timeout discards the LSB, then a fresh pair
      send(8'h34);
      tick(199);
      check("t2_tout_early", 32'(timeout_err), 32'h0);
      tick(1);
      check("t2_tout_set", 32'(timeout_err), 32'h1);
      send(8'hCD);
      send(8'hAB);
      check("t2_fir_in", 32'(FIR_in), 32'hABCD);
      check("t2_start", 32'(FIR_start), 32'h1);
      tick(1);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      check("t2_tout_clr", 32'(timeout_err), 32'h0);
      check("t2_cnt", 32'(sample_cnt), 32'h2);

      // 5: MSB on the exact expiry cycle wins over the timeout
      send(8'h02);
      tick(199);
      send(8'h01);
      check("t5_fir_in", 32'(FIR_in), 32'h0102);
      check("t5_start", 32'(FIR_start), 32'h1);
      check("t5_tout", 32'(timeout_err), 32'h0);
      tick(1);
      check("t5_tout_after", 32'(timeout_err), 32'h0);

      // 3: busy FIR, overrun in HOLD (set beats a simultaneous err_clr)
      FIR_busy = 1'b1;
      snap = pulse_cnt;
      send(8'h22);
      send(8'h11);
      check("t3_fir_in_hold", 32'(FIR_in), 32'h1122);
      check("t3_no_start", 32'(FIR_start), 32'h0);
      err_clr = 1'b1;
      send(8'h55);
      err_clr = 1'b0;
      check("t3_ovr", 32'(overrun), 32'h1);
      tick(48);
      check("t3_no_pulse_busy", 32'(pulse_cnt - snap), 32'h0);
      check("t3_fir_in_kept", 32'(FIR_in), 32'h1122);
      FIR_busy = 1'b0;
      tick(1);
      check("t3_start", 32'(FIR_start), 32'h1);
      check("t3_fir_in", 32'(FIR_in), 32'h1122);
      tick(1);
      check("t3_start_lo", 32'(FIR_start), 32'h0);
      check("t3_one_pulse", 32'(pulse_cnt - snap), 32'h1);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      check("t3_ovr_clr", 32'(overrun), 32'h0);

      // 4: reset after an LSB discards it
      send(8'h99);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("t4_rst_cnt", 32'(sample_cnt), 32'h0);
      check("t4_rst_fir_in", 32'(FIR_in), 32'h0);
      send(8'h78);
      send(8'h56);
      check("t4_fir_in", 32'(FIR_in), 32'h5678);
      tick(1);
      check("t4_cnt", 32'(sample_cnt), 32'h1);

      // 6: 256 back-to-back pairs wrap sample_cnt
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      snap = pulse_cnt;
      for (int i = 0; i < 512; i++) begin
         RxD_data_ready = 1'b1;
         RxD_data       = 8'(i);
         tick(1);
         if (i == 3) check("t6_fir_in_2nd", 32'(FIR_in), 32'h0302);
      end
      RxD_data_ready = 1'b0;
      check("t6_cnt_255", 32'(sample_cnt), 32'hFF);
      check("t6_fir_in_last", 32'(FIR_in), 32'hFFFE);
      tick(1);
      check("t6_cnt_wrap", 32'(sample_cnt), 32'h0);
      check("t6_pulses", 32'(pulse_cnt - snap), 32'd256);
      tick(2);
      check("no_double_start", 32'(dbl_cnt), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
